// File: rtl/cav4_freq_ramp_if.sv
`default_nettype none
// ============================================================================
// Module   : cav4_freq_ramp_if
// Purpose  : Host-side bus for the coarse-frequency slew limiter. Carries the
//            target write, ramp controls and the registered ramp outputs.
// Revision : 1.0  initial release
// ============================================================================
interface cav4_freq_ramp_if #(
  parameter int STEP_W = 16,
  parameter int INTV_W = 16
);
  logic signed [27:0]  target;
  logic                target_we;
  logic [STEP_W-1:0]   step;
  logic [INTV_W-1:0]   interval;
  logic                abort;
  logic signed [27:0]  coarse_freq;
  logic                busy;
  logic                done;

  // Host side: issues targets and controls, observes the ramp
  modport master (
    output target, target_we, step, interval, abort,
    input  coarse_freq, busy, done
  );

  // Ramp block side
  modport slave (
    input  target, target_we, step, interval, abort,
    output coarse_freq, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/cav4_freq_ramp.sv
`default_nettype none
// ============================================================================
// Module   : cav4_freq_ramp
// Purpose  : Slew-rate-limited coarse cavity detune source. Walks a signed
//            28-bit output toward a host-written target in steps of 'step'
//            every 'interval'+1 cycles, so large host writes never show up as
//            frequency jumps downstream. STEP_W must not exceed 27.
// Revision : 1.0  initial release
// ============================================================================
module cav4_freq_ramp #(
  parameter int STEP_W = 16,
  parameter int INTV_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  cav4_freq_ramp_if.slave    bus
);

  localparam int c_FREQ_W = 28;
  localparam int c_DIFF_W = c_FREQ_W + 1;
  localparam logic [c_DIFF_W-1:0] c_DIFF_ONE = c_DIFF_W'(1);
  localparam logic [INTV_W-1:0]   c_CNT_ONE  = INTV_W'(1);
  localparam logic [INTV_W-1:0]   c_CNT_ZERO = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t                       r_state;
  logic signed [c_FREQ_W-1:0]   r_tgt;
  logic signed [c_FREQ_W-1:0]   r_cur;
  logic [INTV_W-1:0]            r_cnt;
  logic                         r_busy;
  logic                         r_done;

  logic [c_DIFF_W-1:0]          w_diff;
  logic                         w_diff_neg;
  logic [c_DIFF_W-1:0]          w_mag;
  logic [c_DIFF_W-1:0]          w_step_diff;
  logic [c_FREQ_W-1:0]          w_step_freq;
  logic                         w_tick;
  logic                         w_close;
  logic [c_FREQ_W-1:0]          w_next;

  // Distance to target in 29 bits so the full 28-bit span cannot wrap
  assign w_diff      = {r_tgt[c_FREQ_W-1], r_tgt} - {r_cur[c_FREQ_W-1], r_cur};
  assign w_diff_neg  = w_diff[c_DIFF_W-1];
  // Magnitude of a 29-bit value; 2^28 is representable as unsigned 29-bit
  assign w_mag       = w_diff_neg ? (~w_diff + c_DIFF_ONE) : w_diff;
  assign w_step_diff = {{(c_DIFF_W-STEP_W){1'b0}}, bus.step};
  assign w_step_freq = {{(c_FREQ_W-STEP_W){1'b0}}, bus.step};

  assign w_tick      = (r_cnt == c_CNT_ZERO);
  // Close enough to land exactly on the target this tick
  assign w_close     = (w_mag <= w_step_diff);
  // Only used when the target is more than one step away, so the result lies
  // strictly between cur and tgt and the 28-bit sum is exact.
  assign w_next      = w_diff_neg ? (r_cur - w_step_freq) : (r_cur + w_step_freq);

  // Ramp state machine with registered output, status and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tgt   <= '0;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Abort has priority over a simultaneous write
          if (bus.target_we && !bus.abort) begin
            r_tgt   <= bus.target;
            r_cnt   <= bus.interval;
            r_state <= ST_RAMP;
            r_busy  <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (bus.abort) begin
            // Freeze output where it is; the abandoned target is not reported
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.target_we) begin
            // Retarget: continue from the present output, restart the period
            r_tgt <= bus.target;
            r_cnt <= bus.interval;
          end else if (w_tick) begin
            r_cnt <= bus.interval;
            if (w_close) begin
              r_cur   <= r_tgt;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              // step == 0 lands here with no movement: a legal stall
              r_cur <= w_next;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coarse_freq = r_cur;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cav4_freq_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cav4_freq_ramp
// Purpose  : Self-checking bench for cav4_freq_ramp: constant vector table,
//            directed multi-cycle sequences and randomized traffic checked
//            against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cav4_freq_ramp;

  logic clk;
  logic rst_n;

  cav4_freq_ramp_if #(.STEP_W(16), .INTV_W(16)) bus ();

  cav4_freq_ramp #(.STEP_W(16), .INTV_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int n_done_seen;

  // Behavioural model: target, output, busy flag and edges left until the
  // next update. Updates are computed with plain integer arithmetic.
  int m_tgt;
  int m_cur;
  int m_busy;
  int m_done;
  int m_wait;

  typedef struct {
    logic signed [27:0] tgt;
    logic               we;
    logic [15:0]        stp;
    logic [15:0]        intv;
    logic               ab;
    logic signed [27:0] e_freq;
    logic               e_busy;
    logic               e_done;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tgt = 0; m_cur = 0; m_busy = 0; m_done = 0; m_wait = 0;
  endtask

  task automatic model_edge();
    int d;
    int mag;
    m_done = 0;
    if (m_busy == 0) begin
      if (bus.target_we && !bus.abort) begin
        m_tgt  = int'(bus.target);
        m_wait = int'(bus.interval) + 1;
        m_busy = 1;
      end
    end else if (bus.abort) begin
      m_busy = 0;
    end else if (bus.target_we) begin
      m_tgt  = int'(bus.target);
      m_wait = int'(bus.interval) + 1;
    end else begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_wait = int'(bus.interval) + 1;
        d   = m_tgt - m_cur;
        mag = (d < 0) ? -d : d;
        if (mag <= int'(bus.step)) begin
          m_cur  = m_tgt;
          m_done = 1;
          m_busy = 0;
        end else if (d > 0) begin
          m_cur = m_cur + int'(bus.step);
        end else begin
          m_cur = m_cur - int'(bus.step);
        end
      end
    end
  endtask

  // One clock: model steps at the edge, DUT is sampled 1 time unit later
  task automatic cyc(input string name);
    @(posedge clk);
    model_edge();
    #1;
    chk({name, "_freq"}, int'(bus.coarse_freq), m_cur);
    chk({name, "_busy"}, int'(bus.busy), m_busy);
    chk({name, "_done"}, int'(bus.done), m_done);
    if (bus.done) n_done_seen++;
  endtask

  task automatic idle_inputs();
    bus.target_we = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic do_reset();
    bus.target = '0; bus.step = '0; bus.interval = '0;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_target(input int t, input int s, input int iv);
    bus.target    = 28'(t);
    bus.step      = 16'(s);
    bus.interval  = 16'(iv);
    bus.target_we = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int mono_ok;
    int ncyc;
    n_cmp = 0; n_bad = 0; n_done_seen = 0;

    // tgt, we, step, intv, abort | freq, busy, done
    vt[0]  = '{28'sd1000, 1'b1, 16'd1000, 16'd0, 1'b0, 28'sd0,    1'b1, 1'b0};
    vt[1]  = '{28'sd1000, 1'b0, 16'd1000, 16'd0, 1'b0, 28'sd1000, 1'b0, 1'b1};
    vt[2]  = '{-28'sd250, 1'b1, 16'd300,  16'd0, 1'b0, 28'sd1000, 1'b1, 1'b0};
    vt[3]  = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, 28'sd700,  1'b1, 1'b0};
    vt[4]  = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, 28'sd400,  1'b1, 1'b0};
    vt[5]  = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, 28'sd100,  1'b1, 1'b0};
    vt[6]  = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, -28'sd200, 1'b1, 1'b0};
    vt[7]  = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, -28'sd250, 1'b0, 1'b1};
    vt[8]  = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, -28'sd250, 1'b0, 1'b0};
    vt[9]  = '{28'sd5,    1'b1, 16'd300,  16'd0, 1'b1, -28'sd250, 1'b0, 1'b0};
    vt[10] = '{28'sd5,    1'b0, 16'd300,  16'd0, 1'b0, -28'sd250, 1'b0, 1'b0};
    vt[11] = '{-28'sd250, 1'b1, 16'd300,  16'd0, 1'b0, -28'sd250, 1'b1, 1'b0};
    vt[12] = '{-28'sd250, 1'b0, 16'd300,  16'd0, 1'b0, -28'sd250, 1'b0, 1'b1};

    rst_n = 1'b0;
    do_reset();
    #1;
    chk("reset_freq", int'(bus.coarse_freq), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);

    // Vector table: partial final down-step, abort-vs-write, equal target
    for (int i = 0; i < 13; i++) begin
      bus.target    = vt[i].tgt;
      bus.target_we = vt[i].we;
      bus.step      = vt[i].stp;
      bus.interval  = vt[i].intv;
      bus.abort     = vt[i].ab;
      cyc("table");
      chk($sformatf("vec%0d_freq", i), int'(bus.coarse_freq), int'(vt[i].e_freq));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vt[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(bus.done), int'(vt[i].e_done));
    end
    idle_inputs();

    // Up-ramp 0 -> 1000, step 100, interval 3: change every 4 edges
    do_reset();
    write_target(1000, 100, 3);
    cyc("up_e0");
    chk("up_e0_busy", int'(bus.busy), 1);
    idle_inputs();
    for (int k = 1; k <= 40; k++) begin
      cyc("up");
      chk("up_freq_k", int'(bus.coarse_freq), 100 * (k / 4));
      chk("up_done_k", int'(bus.done), (k == 40) ? 1 : 0);
    end

    // Extremes: 0 -> -2^27 with step 2^15-1, interval 0
    do_reset();
    write_target(-134217728, 32767, 0);
    cyc("ext_e0");
    idle_inputs();
    prev = 0; mono_ok = 1; ncyc = 0;
    while (bus.busy && ncyc < 5000) begin
      cyc("ext");
      ncyc++;
      if (int'(bus.coarse_freq) > prev) mono_ok = 0;
      prev = int'(bus.coarse_freq);
    end
    chk("ext_final", int'(bus.coarse_freq), -134217728);
    chk("ext_cycles", ncyc, 4097);
    chk("ext_monotonic", mono_ok, 1);

    // Retarget at 500 toward 0: reverses, exactly one done
    do_reset();
    n_done_seen = 0;
    write_target(5000, 10, 0);
    cyc("rt_e0");
    idle_inputs();
    ncyc = 0;
    while (int'(bus.coarse_freq) != 500 && ncyc < 200) begin
      cyc("rt_up");
      ncyc++;
    end
    chk("rt_reached500", int'(bus.coarse_freq), 500);
    write_target(0, 10, 0);
    cyc("rt_we");
    idle_inputs();
    cyc("rt_rev");
    chk("rt_first_rev", int'(bus.coarse_freq), 490);
    ncyc = 0;
    while (bus.busy && ncyc < 200) begin
      cyc("rt_down");
      ncyc++;
    end
    chk("rt_final", int'(bus.coarse_freq), 0);
    chk("rt_done_count", n_done_seen, 1);

    // Abort at 300: output holds, no done
    do_reset();
    n_done_seen = 0;
    write_target(5000, 10, 0);
    cyc("ab_e0");
    idle_inputs();
    ncyc = 0;
    while (int'(bus.coarse_freq) != 300 && ncyc < 200) begin
      cyc("ab_up");
      ncyc++;
    end
    bus.abort = 1'b1;
    cyc("ab_hit");
    idle_inputs();
    chk("ab_busy", int'(bus.busy), 0);
    repeat (5) cyc("ab_hold");
    chk("ab_freq", int'(bus.coarse_freq), 300);
    chk("ab_no_done", n_done_seen, 0);

    // Step 0 stall from 300 toward 1000, then resume with step 5
    write_target(1000, 0, 1);
    cyc("st_e0");
    idle_inputs();
    repeat (10) cyc("st_stall");
    chk("st_frozen", int'(bus.coarse_freq), 300);
    chk("st_busy", int'(bus.busy), 1);
    bus.step = 16'd5;
    ncyc = 0;
    while (bus.busy && ncyc < 400) begin
      cyc("st_resume");
      ncyc++;
    end
    chk("st_final", int'(bus.coarse_freq), 1000);
    chk("st_cycles", ncyc, 280);

    // Asynchronous reset mid-ramp
    write_target(-3000, 7, 2);
    cyc("rs_e0");
    idle_inputs();
    repeat (20) cyc("rs_ramp");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rs_async_freq", int'(bus.coarse_freq), 0);
    chk("rs_async_busy", int'(bus.busy), 0);
    chk("rs_async_done", int'(bus.done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cyc("rs_idle");

    // Randomized traffic against the model
    do_reset();
    for (int r = 0; r < 3000; r++) begin
      bus.target_we = ($urandom_range(0, 19) == 0);
      bus.abort     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0)
        bus.target = 28'($urandom());
      else
        bus.target = 28'(int'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 15) == 0)
        bus.step = 16'd0;
      else if ($urandom_range(0, 15) == 0)
        bus.step = 16'($urandom());
      else
        bus.step = 16'($urandom_range(1, 300));
      bus.interval = 16'($urandom_range(0, 3));
      cyc("rand");
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
